// File: rtl/io_uart_tx_if.sv
// IO bus between the SOC and the UART transmitter: the SOC drives the address/control,
// and the peripheral drives combinational read data.
// Handshake: an access is valid in the cycle IOenable is high. There is no ready signal,
// so every access completes in that same cycle with no wait states.
interface io_uart_tx_if;
  logic [15:0] data_in;
  logic [15:0] port;
  logic        IOenable;
  logic        rw;
  logic [15:0] data_out;
  logic        data_oe;

  modport master (
    output data_in, port, IOenable, rw,
    input  data_out, data_oe
  );

  modport slave (
    input  data_in, port, IOenable, rw,
    output data_out, data_oe
  );
endinterface

// File: rtl/io_uart_tx.sv
// UART 8N1 transmitter on the SOC IO bus: TXDATA pushes into a FIFO, STATUS reads
// {overflow, full, empty, busy}, and the FSM state is visible on fsm_state.
module io_uart_tx #(
  parameter logic [15:0] BASE_PORT    = 16'h0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  io_uart_tx_if.slave   bus,
  output logic          tx,
  output logic          busy,
  output logic [1:0]    fsm_state
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] ST_PORT   = BASE_PORT + 16'd1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  state_t state, state_nx;

  logic          wr_tx, wr_st, rd_st;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, overflow, push, pop;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_last, bit_last;
  logic          unused_hi;

  assign wr_tx = bus.IOenable &  bus.rw & (bus.port == BASE_PORT);
  assign wr_st = bus.IOenable &  bus.rw & (bus.port == ST_PORT);
  assign rd_st = bus.IOenable & ~bus.rw & (bus.port == ST_PORT);
  assign unused_hi = ^bus.data_in[15:8];

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign bit_last  = (bit_idx == 3'd7);
  // A push into a full FIFO is still accepted when the transmitter pops in the same cycle.
  assign push      = wr_tx & (~full | pop);

  assign busy         = (state != IDLE) | ~empty;
  assign bus.data_oe  = rd_st;
  assign bus.data_out = rd_st ? {12'b0, overflow, full, empty, busy} : 16'h0000;
  assign fsm_state    = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set has priority over a clear arriving in the same cycle.
      if (wr_tx & full & ~pop)          overflow <= 1'b1;
      else if (wr_st & bus.data_in[3])  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (~empty)                state_nx = START;
      START:   if (baud_last)             state_nx = DATA;
      DATA:    if (baud_last & bit_last)  state_nx = STOP;
      STOP:    if (baud_last)             state_nx = empty ? IDLE : START;
      default:                            state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop = ~empty & ((state == IDLE) | ((state == STOP) & baud_last));
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else if (pop) begin
      shift    <= mem[rd_ptr];
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (state != IDLE) begin
      if (baud_last) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: a serial-line monitor decodes frames and checks them
// against bytes queued when the CPU writes were driven.
module tb_io_uart_tx;
  localparam int          C    = 4;
  localparam logic [15:0] BASE = 16'h0010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx, busy;
  logic [1:0] fsm_state;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];

  io_uart_tx_if bus();

  io_uart_tx #(.BASE_PORT(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_write(input logic [15:0] p, input logic [15:0] d);
    @(posedge clk); #1;
    bus.port = p; bus.data_in = d; bus.rw = 1'b1; bus.IOenable = 1'b1;
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    bus.IOenable = 1'b0; bus.rw = 1'b0; bus.port = 16'h0000; bus.data_in = 16'h0000;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] p, input logic en,
                          input logic exp_oe, input logic [15:0] exp_out);
    @(posedge clk); #1;
    bus.port = p; bus.rw = 1'b0; bus.IOenable = en;
    #2;
    chk({tag, "_oe"}, 16'(bus.data_oe), 16'(exp_oe));
    chk({tag, "_out"}, bus.data_out, exp_out);
    bus_idle();
  endtask

  task automatic wait_idle(input string tag, input int bound, output int cycles);
    cycles = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
      if (cycles >= bound) break;
    end
    chk({tag, "_timeout"}, 16'(busy), 16'h0000);
  endtask

  // Frame monitor: samples every cycle at negedge, checks start/stop levels and
  // per-bit stability, then compares the decoded byte with the scoreboard head.
  initial begin
    int         cnt;
    int         b;
    logic [7:0] rx;
    logic       act;
    logic [7:0] exp_b;
    act = 1'b0; cnt = 0; rx = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin act = 1'b1; cnt = 1; end
      end else begin
        b = cnt / C;
        if (b == 0)                  chk("mon_start", 16'(tx), 16'h0000);
        else if (b == 9)             chk("mon_stop", 16'(tx), 16'h0001);
        else if (cnt % C == 0)       rx[b-1] = tx;
        else                         chk("mon_bit_stable", 16'(tx), 16'(rx[b-1]));
        cnt++;
        if (cnt == 10 * C) begin
          act = 1'b0;
          chk("mon_q_nonempty", 16'(exp_q.size() > 0), 16'h0001);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            chk("mon_byte", 16'(rx), 16'(exp_b));
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int bad;
    bus.IOenable = 1'b0; bus.rw = 1'b0; bus.port = 16'h0000; bus.data_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_tx", 16'(tx), 16'h0001);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_fsm", 16'(fsm_state), 16'h0000);
    read_chk("rst_status", BASE + 16'd1, 1'b1, 1'b1, 16'h0002);

    // Single byte 0x55: latency and frame timing
    exp_q.push_back(8'h55);
    drive_write(BASE, 16'hAB55);
    bus_idle();
    @(negedge clk);
    chk("lat_n1_tx", 16'(tx), 16'h0001);
    chk("lat_n1_busy", 16'(busy), 16'h0001);
    @(negedge clk);
    chk("lat_n2_tx", 16'(tx), 16'h0000);
    chk("lat_n2_fsm", 16'(fsm_state), 16'h0001);
    repeat (39) @(negedge clk);
    chk("frame_last_busy", 16'(busy), 16'h0001);
    @(negedge clk);
    chk("frame_end_busy", 16'(busy), 16'h0000);
    chk("frame_end_tx", 16'(tx), 16'h0001);
    read_chk("single_status", BASE + 16'd1, 1'b1, 1'b1, 16'h0002);

    // Three back-to-back bytes: contiguous frames
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      drive_write(BASE, 16'(i));
    end
    bus_idle();
    wait_idle("burst3", 500, cyc);
    chk("burst3_busy_cycles", 16'(cyc), 16'd119);

    // Ten writes while idle: nine accepted, tenth overflows
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'hA0 + 8'(i));
      drive_write(BASE, {8'hFF, 8'hA0 + 8'(i)});
    end
    bus_idle();
    read_chk("ovf_status", BASE + 16'd1, 1'b1, 1'b1, 16'h000D);
    drive_write(BASE + 16'd1, 16'h0008);
    bus_idle();
    read_chk("ovf_clr_status", BASE + 16'd1, 1'b1, 1'b1, 16'h0005);
    wait_idle("ovf_drain", 1000, cyc);
    read_chk("ovf_drain_status", BASE + 16'd1, 1'b1, 1'b1, 16'h0002);

    // Read decode
    read_chk("rd_other_port", BASE + 16'd2, 1'b1, 1'b0, 16'h0000);
    read_chk("rd_no_enable", BASE + 16'd1, 1'b0, 1'b0, 16'h0000);
    read_chk("rd_txdata", BASE, 1'b1, 1'b0, 16'h0000);

    // Reset at data bit 3 with four bytes queued
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      drive_write(BASE, 16'hC0 + 16'(i));
    end
    bus_idle();
    repeat (13) @(negedge clk);
    chk("mid_fsm_data", 16'(fsm_state), 16'h0002);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    bus.port = BASE; bus.data_in = 16'h0077; bus.rw = 1'b1; bus.IOenable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.IOenable = 1'b0; bus.rw = 1'b0; bus.port = 16'h0000; bus.data_in = 16'h0000;
    @(negedge clk);
    chk("mid_rst_tx", 16'(tx), 16'h0001);
    chk("mid_rst_busy", 16'(busy), 16'h0000);
    read_chk("mid_rst_status", BASE + 16'd1, 1'b1, 1'b1, 16'h0002);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("mid_rst_quiet", 16'(bad), 16'h0000);

    // Write cycle without IOenable is ignored
    @(posedge clk); #1;
    bus.port = BASE; bus.data_in = 16'h1234; bus.rw = 1'b1; bus.IOenable = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    bus_idle();
    chk("noen_quiet", 16'(bad), 16'h0000);
    read_chk("noen_status", BASE + 16'd1, 1'b1, 1'b1, 16'h0002);

    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- IO-bus responder peripheral for the SOC's 16-bit IO interface (data, port, IOenable, rw).
- CPU IO writes to the TXDATA port queue bytes in an internal FIFO.
- Bytes are serialized as UART 8N1 on `tx`.
- CPU IO reads from the STATUS port return FIFO/transmitter state on a driven read-data bus.

Parameters:
- BASE_PORT, 16'h0000: IO port of TXDATA; STATUS is at BASE_PORT+1.
- CLKS_PER_BIT, 868: clk cycles per UART bit, legal range 2..65535.
- FIFO_DEPTH, 8: FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_in  in  16  IO write data from SOC
- port  in  16  IO port address from SOC
- IOenable  in  1  IO access qualifier
- rw  in  1  1 = write, 0 = read
- data_out  out  16  read data; 16'h0000 when data_oe=0
- data_oe  out  1  high when this block is driving read data
- tx  out  1  UART serial line, idle high
- busy  out  1  FIFO non-empty or frame in progress

Behaviour:
- Access decode, per cycle, no wait states:
  - wr_tx = IOenable & rw & (port==BASE_PORT)
  - wr_st = IOenable & rw & (port==BASE_PORT+1)
  - rd_st = IOenable & !rw & (port==BASE_PORT+1)
  - All other ports are ignored.
- Each cycle wr_tx is high counts as one push of data_in[7:0]. data_in[15:8] is ignored.
- STATUS word = {12'b0, overflow, full, empty, busy}.
  - data_oe = rd_st, combinational.
  - data_out = STATUS when rd_st, else 0.
  - The read has no side effects. Reading TXDATA returns data_oe=0.
- wr_st with data_in[3]=1 clears overflow. Other bits are ignored.
- Register reset values:
  - tx=1, FIFO empty, count=0, overflow=0, FSM=IDLE.
  - busy=0, data_oe=0, data_out=0 (these follow combinationally from the registers).
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - count is (log2(FIFO_DEPTH)+1) bits wide.
  - Push when full and no pop in the same cycle: data is dropped and overflow is set (sticky).
  - Push when full with a pop in the same cycle: push accepted, count unchanged.
  - Simultaneous push and pop at any level: count unchanged, ordering preserved.
  - Set and clear of overflow in the same cycle: set wins.
- FSM, states IDLE, START, DATA, STOP:
  - Baud counter runs 0..CLKS_PER_BIT-1. Bit index runs 0..7.
  - IDLE: if !empty, pop the head into shift register, reset baud counter, go to START. tx is low from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles. Then shift right. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if !empty, pop immediately and go to START with no idle cycle. Otherwise go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles. LSB first.
- Latency:
  - Write at cycle N to an empty, idle block: FIFO holds the byte at N+1, pop at N+1, tx falls at N+2.
  - busy = (state!=IDLE) | !empty, so busy is high from N+1.
- A FIFO push during an active frame never disturbs the frame in flight.
- Reset mid-frame, synchronous:
  - tx=1 at the next edge, frame abandoned.
  - FIFO flushed, overflow cleared.
  - An IO write in the same cycle as reset is discarded.

Test Plan:
- CLKS_PER_BIT=4, BASE_PORT=16'h0010; write 16'hAB55 to 16'h0010 at cycle N:
  - tx=0 over cycles N+2..N+5.
  - Data bits 1,0,1,0,1,0,1,0 (0x55, LSB first), 4 cycles each.
  - Stop high 4 cycles; then busy=0 and STATUS reads 16'h0002.
- Write 3 bytes 0x01,0x02,0x03 on consecutive cycles:
  - Three contiguous 40-cycle frames, no idle gap, correct order.
  - busy falls the cycle after the last stop bit ends.
- FIFO_DEPTH=8; write 10 bytes back-to-back while tx is idle:
  - The first byte is popped at the second write cycle, so 9 bytes are accepted and the 10th sets overflow.
  - STATUS = 16'h000D (overflow|full|busy).
  - Write 16'h0008 to 16'h0011, then STATUS reads 16'h0005.
- Read 16'h0011 with rw=0 and IOenable=1: data_oe=1 the same cycle. Read 16'h0012, or IOenable=0: data_oe=0, data_out=0.
- Assert reset at bit 3 of a frame with 4 bytes queued:
  - tx=1 next cycle.
  - After release, STATUS=16'h0002; no further frames are sent.
- With IOenable=0, rw=1, port=16'h0010: no push, tx stays 1, busy stays 0.
